// File: rtl/sm4_pkg.sv
// Shared types and constants for the SM4 engine front-end arbiter.
package sm4_pkg;

    localparam int num_req_lp         = 4;
    localparam int req_id_width_lp    = $clog2(num_req_lp);
    localparam int sm4_block_width_lp = 128;

    typedef logic [req_id_width_lp-1:0] req_id_t;

    typedef enum logic [1:0] {
        e_idle,
        e_issue,
        e_wait,
        e_resp
    } state_e;

    function automatic logic [num_req_lp-1:0] id_to_onehot(input req_id_t id);
        logic [num_req_lp-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/sm4_req_arbiter_priority_encoder.sv
// Purpose: index of the lowest set bit of bits_i, optional any-bit-set flag.
// Latency: purely combinational.
// Backpressure: none; no handshake.
module priority_encoder #(
    parameter int width_p     = 4,
    parameter bit valid_bit_p = 1'b1,
    localparam int lg_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
    input  logic [width_p-1:0]     bits_i,
    output logic [lg_width_lp-1:0] addr_o,
    output logic                   v_o
);

    // Scan high to low so the lowest set bit wins the last assignment.
    always_comb begin
        addr_o = '0;
        for (int k = width_p - 1; k >= 0; k--) begin
            if (bits_i[k]) begin
                addr_o = k[lg_width_lp-1:0];
            end
        end
    end

    assign v_o = valid_bit_p ? (|bits_i) : 1'b0;

endmodule

// File: rtl/sm4_req_arbiter.sv
// Purpose: round-robin share of one SM4 engine among four requesters, one whole transaction per grant.
// Latency: accept T, engine issue T+1, result T+2, response T+3, next accept T+4 at best.
// Backpressure: engine ready and per-requester response ready stall in place; requesters hold req_v_i while busy.
module sm4_req_arbiter
    import sm4_pkg::*;
#(
    parameter int data_width_p = sm4_block_width_lp
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [num_req_lp-1:0]                   req_v_i,
    input  logic [num_req_lp-1:0][data_width_p-1:0] req_data_i,
    output logic [num_req_lp-1:0]                   req_yumi_o,
    output logic                                    eng_v_o,
    output logic [data_width_p-1:0]                 eng_data_o,
    input  logic                                    eng_ready_i,
    input  logic                                    eng_v_i,
    input  logic [data_width_p-1:0]                 eng_data_i,
    output logic                                    eng_yumi_o,
    output logic [num_req_lp-1:0]                   resp_v_o,
    output logic [data_width_p-1:0]                 resp_data_o,
    input  logic [num_req_lp-1:0]                   resp_ready_i,
    output logic [req_id_width_lp-1:0]              grant_id_o,
    output logic                                    busy_o
);

    state_e                  state_r, state_n;
    req_id_t                 last_grant_r;
    req_id_t                 grant_r;
    logic [data_width_p-1:0] block_r;
    logic [data_width_p-1:0] result_r;

    req_id_t                 start_id;
    req_id_t                 enc_addr;
    req_id_t                 winner;
    logic                    any_req;
    logic [num_req_lp-1:0]   rot_req;
    logic                    accept;
    logic                    complete;

    // Search begins one past the last served requester so it ends up lowest priority.
    assign start_id = last_grant_r + req_id_t'(1);

    always_comb begin
        rot_req = '0;
        for (int j = 0; j < num_req_lp; j++) begin
            rot_req[j] = req_v_i[start_id + req_id_t'(j)];
        end
    end

    priority_encoder #(
        .width_p    (num_req_lp),
        .valid_bit_p(1'b1)
    ) u_prio_enc (
        .bits_i(rot_req),
        .addr_o(enc_addr),
        .v_o   (any_req)
    );

    assign winner = enc_addr + start_id;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= e_idle;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n    = state_r;
        accept     = 1'b0;
        complete   = 1'b0;
        eng_v_o    = 1'b0;
        eng_yumi_o = 1'b0;
        resp_v_o   = '0;
        case (state_r)
            e_idle: begin
                if (any_req) begin
                    accept  = 1'b1;
                    state_n = e_issue;
                end
            end
            e_issue: begin
                eng_v_o = 1'b1;
                if (eng_ready_i) begin
                    state_n = e_wait;
                end
            end
            e_wait: begin
                if (eng_v_i) begin
                    eng_yumi_o = 1'b1;
                    state_n    = e_resp;
                end
            end
            e_resp: begin
                resp_v_o = id_to_onehot(grant_r);
                if (resp_ready_i[grant_r]) begin
                    complete = 1'b1;
                    state_n  = e_idle;
                end
            end
            default: state_n = e_idle;
        endcase
    end

    // While reset is asserted nothing would be captured, so no requester may see an accept.
    assign req_yumi_o = (accept && rst_ni) ? id_to_onehot(winner) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_r <= req_id_t'(num_req_lp - 1);
            grant_r      <= '0;
        end else begin
            if (accept) begin
                grant_r <= winner;
            end
            if (complete) begin
                last_grant_r <= grant_r;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            block_r <= '0;
        end else if (accept) begin
            block_r <= req_data_i[winner];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_r <= '0;
        end else if (eng_yumi_o) begin
            result_r <= eng_data_i;
        end
    end

    assign eng_data_o  = block_r;
    assign resp_data_o = result_r;
    assign grant_id_o  = grant_r;
    assign busy_o      = (state_r != e_idle);

endmodule

// File: tb/tb_sm4_req_arbiter.sv
// Directed bench for sm4_req_arbiter: hand-computed grants, data and cycle timing.
module tb_sm4_req_arbiter;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        req_v;
    logic [3:0][127:0] req_data;
    logic [3:0]        req_yumi;
    logic              eng_v;
    logic [127:0]      eng_data;
    logic              eng_ready;
    logic              eng_v_in;
    logic [127:0]      eng_data_in;
    logic              eng_yumi;
    logic [3:0]        resp_v;
    logic [127:0]      resp_data;
    logic [3:0]        resp_ready;
    logic [1:0]        grant_id;
    logic              busy;

    int passed = 0;
    int total  = 0;

    localparam logic [127:0] res_b = 128'hbbbb_0000_1111_2222_3333_4444_5555_6666;

    always #5 clk = ~clk;

    sm4_req_arbiter dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_v_i     (req_v),
        .req_data_i  (req_data),
        .req_yumi_o  (req_yumi),
        .eng_v_o     (eng_v),
        .eng_data_o  (eng_data),
        .eng_ready_i (eng_ready),
        .eng_v_i     (eng_v_in),
        .eng_data_i  (eng_data_in),
        .eng_yumi_o  (eng_yumi),
        .resp_v_o    (resp_v),
        .resp_data_o (resp_data),
        .resp_ready_i(resp_ready),
        .grant_id_o  (grant_id),
        .busy_o      (busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction from the accept cycle; engine ready and resp_ready[id] must already be high.
    task automatic txn(input logic [1:0] id, input logic [127:0] res);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        #1;
        chk("accept_yumi", 128'(req_yumi), 128'(oh));
        tick();
        chk("issue_eng_v", 128'(eng_v), 128'(1'b1));
        chk("issue_data", eng_data, req_data[id]);
        chk("issue_grant", 128'(grant_id), 128'(id));
        chk("busy_no_yumi", 128'(req_yumi), 128'(4'b0000));
        tick();
        eng_v_in    = 1'b1;
        eng_data_in = res;
        #1;
        chk("wait_eng_yumi", 128'(eng_yumi), 128'(1'b1));
        tick();
        eng_v_in = 1'b0;
        #1;
        chk("resp_v", 128'(resp_v), 128'(oh));
        chk("resp_data", resp_data, res);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        req_v       = 4'b0000;
        eng_ready   = 1'b0;
        eng_v_in    = 1'b0;
        eng_data_in = '0;
        resp_ready  = 4'b0000;
        req_data[0] = 128'h0000_0000_aaaa_aaaa_0000_0000_aaaa_aaa0;
        req_data[1] = 128'h1111_1111_bbbb_bbbb_1111_1111_bbbb_bbb1;
        req_data[2] = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        req_data[3] = 128'h3333_3333_dddd_dddd_3333_3333_dddd_ddd3;
        repeat (2) tick();

        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_grant", 128'(grant_id), 128'(2'd0));
        chk("rst_eng_v", 128'(eng_v), 128'(1'b0));
        chk("rst_resp_v", 128'(resp_v), 128'(4'b0000));
        chk("rst_eng_data", eng_data, 128'h0);
        chk("rst_resp_data", resp_data, 128'h0);

        // Round-robin from reset: requester 0 first.
        rst_n      = 1'b1;
        req_v      = 4'b1111;
        eng_ready  = 1'b1;
        resp_ready = 4'b1111;
        txn(2'd0, 128'hc0de_0000_0000_0000_0000_0000_0000_0000);
        txn(2'd1, 128'hc0de_0000_0000_0000_0000_0000_0000_0001);
        txn(2'd2, 128'hc0de_0000_0000_0000_0000_0000_0000_0002);
        txn(2'd3, 128'hc0de_0000_0000_0000_0000_0000_0000_0003);
        txn(2'd0, 128'hc0de_0000_0000_0000_0000_0000_0000_0004);

        // Bring last_grant to 1, then 0011 must wrap to requester 0 before 1.
        req_v = 4'b0010;
        txn(2'd1, 128'h5151_5151_5151_5151_5151_5151_5151_5151);
        req_v = 4'b0011;
        txn(2'd0, 128'h5050_5050_5050_5050_5050_5050_5050_5050);
        req_v = 4'b0010;
        txn(2'd1, 128'h5252_5252_5252_5252_5252_5252_5252_5252);

        // Single request with the SM4 reference block.
        req_v = 4'b0100;
        txn(2'd2, 128'h681e_df34_d206_965e_86b3_e94f_536e_4246);
        req_v = 4'b0000;
        #1;
        chk("idle_busy", 128'(busy), 128'(1'b0));
        chk("idle_resp_v", 128'(resp_v), 128'(4'b0000));

        // Stray engine result while idle.
        eng_v_in = 1'b1;
        #1;
        chk("stray_idle_yumi", 128'(eng_yumi), 128'(1'b0));
        tick();
        chk("stray_idle_busy", 128'(busy), 128'(1'b0));
        eng_v_in = 1'b0;

        // Backpressure: engine not ready for 5 cycles, response not ready for 3.
        req_v      = 4'b1000;
        eng_ready  = 1'b0;
        resp_ready = 4'b0000;
        #1;
        chk("bp_accept", 128'(req_yumi), 128'(4'b1000));
        tick();
        req_v    = 4'b1001;
        eng_v_in = 1'b1;
        #1;
        chk("stray_issue_yumi", 128'(eng_yumi), 128'(1'b0));
        chk("bp_eng_v0", 128'(eng_v), 128'(1'b1));
        chk("bp_eng_data0", eng_data, req_data[3]);
        chk("bp_no_accept0", 128'(req_yumi), 128'(4'b0000));
        eng_v_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("bp_eng_v", 128'(eng_v), 128'(1'b1));
            chk("bp_eng_data", eng_data, req_data[3]);
            chk("bp_no_accept", 128'(req_yumi), 128'(4'b0000));
            chk("bp_busy", 128'(busy), 128'(1'b1));
        end
        eng_ready = 1'b1;
        tick();
        chk("bp_wait_eng_v", 128'(eng_v), 128'(1'b0));
        eng_v_in    = 1'b1;
        eng_data_in = res_b;
        #1;
        chk("bp_eng_yumi", 128'(eng_yumi), 128'(1'b1));
        tick();
        eng_v_in    = 1'b0;
        eng_data_in = '0;
        resp_ready  = 4'b0111;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("bp_resp_v", 128'(resp_v), 128'(4'b1000));
            chk("bp_resp_data", resp_data, res_b);
            chk("bp_resp_no_accept", 128'(req_yumi), 128'(4'b0000));
            if (c < 2) tick();
        end
        resp_ready = 4'b1000;
        tick();
        chk("bp_done_busy", 128'(busy), 128'(1'b0));
        chk("bp_next_accept", 128'(req_yumi), 128'(4'b0001));
        resp_ready = 4'b0001;
        txn(2'd0, 128'h0f0f_0f0f_0f0f_0f0f_0f0f_0f0f_0f0f_0f0f);

        // last_grant is 0, so 1001 now picks 3; reset it while waiting on the engine.
        #1;
        chk("pre_rst_accept", 128'(req_yumi), 128'(4'b1000));
        tick();
        tick();
        chk("pre_rst_busy", 128'(busy), 128'(1'b1));
        chk("pre_rst_grant", 128'(grant_id), 128'(2'd3));
        rst_n    = 1'b0;
        eng_v_in = 1'b1;
        #1;
        chk("mid_rst_busy", 128'(busy), 128'(1'b0));
        chk("mid_rst_grant", 128'(grant_id), 128'(2'd0));
        chk("mid_rst_yumi", 128'(req_yumi), 128'(4'b0000));
        chk("mid_rst_eng_yumi", 128'(eng_yumi), 128'(1'b0));
        chk("mid_rst_eng_v", 128'(eng_v), 128'(1'b0));
        chk("mid_rst_resp_v", 128'(resp_v), 128'(4'b0000));
        chk("mid_rst_eng_data", eng_data, 128'h0);
        chk("mid_rst_resp_data", resp_data, 128'h0);
        tick();
        rst_n    = 1'b1;
        eng_v_in = 1'b0;
        txn(2'd0, 128'h9999_8888_7777_6666_5555_4444_3333_2222);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sm4_req_arbiter.md
# sm4_req_arbiter

Round-robin scheduler that shares one SM4 encryption engine between four requesters (e.g. cache refill path, writeback path, two host ports). It grants at most one requester at a time and holds the grant for a whole transaction: accept block, issue it to the engine, collect the result, return it to the granted requester. The fair-choice step uses a 4-bit priority encoder on a rotated request vector. It sits between requester front-ends and the single SM4 core instance.

## Interface
- data_width_p, 128, width of one SM4 data block
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- req_v_i  in  4  request valid, one bit per requester
- req_data_i  in  4 x data_width_p  request plaintext block per requester
- req_yumi_o  out  4  one-hot accept pulse; data captured in that cycle
- eng_v_o  out  1  block valid toward engine
- eng_data_o  out  data_width_p  block toward engine (registered)
- eng_ready_i  in  1  engine accepts block when eng_v_o & eng_ready_i
- eng_v_i  in  1  engine result valid
- eng_data_i  in  data_width_p  engine result
- eng_yumi_o  out  1  result consumed pulse
- resp_v_o  out  4  one-hot response valid to granted requester
- resp_data_o  out  data_width_p  response block (registered, shared)
- resp_ready_i  in  4  per-requester response ready
- grant_id_o  out  2  index of current/last granted requester
- busy_o  out  1  high in any state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_v_i, pick winner = first set bit at or after (last_grant+1) mod 4, wrapping. Assert req_yumi_o[winner] combinationally, latch req_data_i[winner] into block register, latch winner into grant register, go ISSUE. No request: stay.
- ISSUE: eng_v_o=1 with block register; on eng_ready_i go WAIT. eng_v_o held stable until accepted.
- WAIT: on eng_v_i, latch eng_data_i into result register, eng_yumi_o=1 same cycle, go RESP. eng_v_i in IDLE/ISSUE/RESP ignored, eng_yumi_o stays 0.
- RESP: resp_v_o[grant]=1; on resp_ready_i[grant], update last_grant=grant, go IDLE. resp_ready_i of non-granted requesters ignored.
- Requests arriving while busy are not accepted (req_yumi_o=0); requesters hold req_v_i.
- Pointer update only at transaction completion, so a requester is never starved: after requester k is served, k has lowest priority.
- Index arithmetic is 2-bit, wrap mod 4 implicit.

## Timing
- Reset (async assert, any state): state=IDLE, last_grant=3 (requester 0 first), grant=0, block/result registers=0; all outputs 0, grant_id_o=0, busy_o=0. Mid-transaction reset abandons the transaction; no response is issued.
- Request accept: same cycle as req_v_i seen in IDLE.
- eng_v_o first high: cycle after accept.
- Best case request-to-response: accept cycle T, issue T+1 (ready=1), WAIT T+2 with eng_v_i, resp_v_o at T+3, handshake T+3, back in IDLE T+4. Next accept earliest T+4.
- resp_data_o and eng_data_o stable while their valid is high.

## Structure
- Shared package sm4_pkg: state enum (IDLE, ISSUE, WAIT, RESP), localparam num_req_lp=4, sm4 block width constant.
- Sub-module: priority_encoder (valid_bit_p=1) applied to req_v_i rotated right by last_grant+1. Winner = encoder output + last_grant + 1, mod 4. All-zero input is gated by the any-request check.
- FSM plus three registers (block, result, grant/last_grant). No other sub-modules.

## Test plan
- Single request: req_v_i=4'b0100, data 0x0123…, engine ready immediately, result 0x681E… -> req_yumi_o=4'b0100 at T, eng_v_o at T+1, resp_v_o=4'b0100 with 0x681E… at T+3.
- Round-robin: req_v_i=4'b1111 held, responses always ready -> grant order 0,1,2,3,0.
- Skip: last_grant=1, req_v_i=4'b0011 -> grant 0, then 1.
- Backpressure: eng_ready_i low 5 cycles, resp_ready_i low 3 cycles -> eng_v_o/data and resp_v_o/data held stable; no new req_yumi_o while busy_o=1.
- Stray signals: eng_v_i pulsed in IDLE and ISSUE, resp_ready_i of non-granted bits -> no state change, eng_yumi_o=0.
- Reset in WAIT: deassert rst_ni -> all outputs 0 immediately; after release, req_v_i=4'b1001 -> grant 0 (last_grant reset to 3).
